// File: rtl/megarom_mapper_engine.sv
// MSX MegaROM mapper: bank-register decode plus a req/ack RAM back end that holds the Z80 with WAIT_n.
// Optional feature macro MEGAROM_READBACK_EN: reads of a bank-register address return the register value.
module megarom_mapper_engine #(
  parameter int unsigned BANK_COUNT = 4,
  parameter int unsigned BANK_BITS  = 8,
  parameter int unsigned ADDR_WIDTH = 24
) (
  input  logic                            CLK,
  input  logic                            RESET_n,
  input  logic                            BUS_RESET_n,
  input  logic [15:0]                     BUS_ADDR,
  input  logic [7:0]                      BUS_DIN,
  input  logic                            BUS_RD_n,
  input  logic                            BUS_WR_n,
  input  logic                            BUS_MERQ_n,
  input  logic                            BUS_SLTSL_n,
  output logic [7:0]                      BUS_DOUT,
  output logic                            BUS_BUSDIR_n,
  output logic                            BUS_WAIT_n,
  input  logic [ADDR_WIDTH-1:0]           CFG_TOP_ADDR,
  input  logic                            CFG_BANK16,
  input  logic                            CFG_WP,
  input  logic [15:0]                     CFG_REG_ADDR_MASK,
  input  logic [16*BANK_COUNT-1:0]        CFG_REG_ADDR,
  input  logic [BANK_BITS-1:0]            CFG_REG_MASK,
  input  logic [BANK_BITS*BANK_COUNT-1:0] CFG_REG_INIT,
  output logic [BANK_BITS*BANK_COUNT-1:0] BANK_REG,
  output logic                            RAM_REQ,
  output logic                            RAM_WE,
  output logic [ADDR_WIDTH-1:0]           RAM_ADDR,
  output logic [7:0]                      RAM_WDATA,
  input  logic                            RAM_ACK,
  input  logic [7:0]                      RAM_RDATA
);

  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned BW = BANK_BITS;
  localparam int unsigned BC = BANK_COUNT;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t          state;
  logic [BW-1:0]   bank_q [BC];
  logic            rd_prev;
  logic            wr_prev;
  logic            op_wr_q;
  logic            rel_q;

  logic            slot_act;
  logic            rd_act;
  logic            wr_act;
  logic            rd_edge;
  logic            wr_edge;
  logic            op_act;
  logic            in_win;
  logic [1:0]      win_idx;
  logic [BW-1:0]   bank_sel;
  logic [AW-1:0]   map_addr;
  logic [BC-1:0]   reg_match;
  logic [BW-1:0]   wr_val;

  // Strobe qualification and edge detection against the previous sample
  assign slot_act = ~BUS_SLTSL_n & ~BUS_MERQ_n;
  assign rd_act   = slot_act & ~BUS_RD_n;
  assign wr_act   = slot_act & ~BUS_WR_n;
  assign rd_edge  = rd_act & ~rd_prev;
  assign wr_edge  = wr_act & ~wr_prev;
  assign op_act   = op_wr_q ? wr_act : rd_act;
  assign in_win   = (BUS_ADDR[15:14] == 2'b01) || (BUS_ADDR[15:14] == 2'b10);
  assign win_idx  = CFG_BANK16 ? {1'b0, BUS_ADDR[15]} : 2'(BUS_ADDR[15:13] - 3'd2);
  assign wr_val   = BW'(BUS_DIN) & CFG_REG_MASK;

  // Bank lookup; windows beyond the implemented registers map to themselves
  always_comb begin
    bank_sel = BW'(win_idx);
    for (int i = 0; i < int'(BC); i++) begin
      if (win_idx == 2'(i)) bank_sel = bank_q[i];
    end
  end

  always_comb begin
    if (CFG_BANK16) map_addr = CFG_TOP_ADDR + (AW'(bank_sel) << 14) + AW'(BUS_ADDR[13:0]);
    else            map_addr = CFG_TOP_ADDR + (AW'(bank_sel) << 13) + AW'(BUS_ADDR[12:0]);
  end

  always_comb begin
    for (int i = 0; i < int'(BC); i++) begin
      reg_match[i] = ((BUS_ADDR & CFG_REG_ADDR_MASK) == CFG_REG_ADDR[16*i +: 16]);
    end
  end

`ifdef MEGAROM_READBACK_EN
  logic       rb_hit;
  logic [7:0] rb_data;

  // Lowest matching register wins the readback
  always_comb begin
    rb_hit  = |reg_match;
    rb_data = '0;
    for (int i = int'(BC) - 1; i >= 0; i--) begin
      if (reg_match[i]) rb_data = 8'(bank_q[i]);
    end
  end
`endif

  for (genvar g = 0; g < int'(BC); g++) begin : g_bank_out
    assign BANK_REG[g*BW +: BW] = bank_q[g];
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state        <= ST_IDLE;
      rd_prev      <= 1'b0;
      wr_prev      <= 1'b0;
      op_wr_q      <= 1'b0;
      rel_q        <= 1'b0;
      RAM_REQ      <= 1'b0;
      RAM_WE       <= 1'b0;
      RAM_ADDR     <= '0;
      RAM_WDATA    <= '0;
      BUS_DOUT     <= '0;
      BUS_BUSDIR_n <= 1'b1;
      BUS_WAIT_n   <= 1'b1;
      for (int i = 0; i < int'(BC); i++) bank_q[i] <= '0;
    end else begin
      rd_prev <= rd_act;
      wr_prev <= wr_act;
      if (!BUS_RESET_n) begin
        // Bus reset aborts any transaction without waiting for an ack
        state        <= ST_IDLE;
        op_wr_q      <= 1'b0;
        rel_q        <= 1'b0;
        RAM_REQ      <= 1'b0;
        RAM_WE       <= 1'b0;
        RAM_ADDR     <= '0;
        RAM_WDATA    <= '0;
        BUS_DOUT     <= '0;
        BUS_BUSDIR_n <= 1'b1;
        BUS_WAIT_n   <= 1'b1;
        for (int i = 0; i < int'(BC); i++) bank_q[i] <= CFG_REG_INIT[i*BW +: BW];
      end else begin
        if (wr_edge) begin
          for (int i = 0; i < int'(BC); i++) begin
            if (reg_match[i]) bank_q[i] <= wr_val;
          end
        end

        case (state)
          ST_IDLE: begin
`ifdef MEGAROM_READBACK_EN
            if (rd_edge && in_win && rb_hit) begin
              op_wr_q      <= 1'b0;
              BUS_DOUT     <= rb_data;
              BUS_BUSDIR_n <= 1'b0;
              state        <= ST_HOLD;
            end else
`endif
            if ((rd_edge || (wr_edge && !CFG_WP)) && in_win) begin
              op_wr_q      <= ~rd_edge;
              rel_q        <= 1'b0;
              RAM_REQ      <= 1'b1;
              RAM_WE       <= ~rd_edge;
              RAM_ADDR     <= map_addr;
              RAM_WDATA    <= BUS_DIN;
              BUS_WAIT_n   <= 1'b0;
              BUS_BUSDIR_n <= ~rd_edge;
              state        <= ST_BUSY;
            end
          end

          ST_BUSY: begin
            // A strobe dropped mid-transaction stops driving the bus but lets RAM finish
            if (!op_act) begin
              rel_q        <= 1'b1;
              BUS_BUSDIR_n <= 1'b1;
            end
            if (RAM_ACK) begin
              RAM_REQ    <= 1'b0;
              BUS_WAIT_n <= 1'b1;
              if (rel_q || !op_act) begin
                BUS_DOUT     <= '0;
                BUS_BUSDIR_n <= 1'b1;
                state        <= ST_IDLE;
              end else begin
                if (!op_wr_q) BUS_DOUT <= RAM_RDATA;
                state <= ST_HOLD;
              end
            end
          end

          ST_HOLD: begin
            if (!op_act) begin
              BUS_DOUT     <= '0;
              BUS_BUSDIR_n <= 1'b1;
              state        <= ST_IDLE;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_megarom_mapper_engine.sv
// Randomized self-checking bench: a 4x8-bit mapper and a 1x10-bit mapper share one MSX bus, checked against an arithmetic model.
`timescale 1ns/1ps
module tb_megarom_mapper_engine;

  logic        CLK = 1'b0;
  logic        RESET_n, BUS_RESET_n;
  logic [15:0] bus_addr;
  logic [7:0]  bus_din;
  logic        rd_n, wr_n, merq_n, sltsl_n;
  logic [23:0] top;
  logic        bank16, wp;
  logic [15:0] reg_addr_mask;

  logic [63:0] reg_addr_a = 64'hA000_8000_6000_5000;
  logic [7:0]  reg_mask_a = 8'h7F;
  logic [31:0] init_a     = 32'h0302_0100;
  logic [15:0] reg_addr_b = 16'h5000;
  logic [9:0]  reg_mask_b = 10'h3FF;
  logic [9:0]  init_b     = 10'h2A5;

  logic [7:0]  dout_a, dout_b, wdata_a, wdata_b;
  logic        busdir_a, busdir_b, wait_a, wait_b;
  logic [31:0] bank_reg_a;
  logic [9:0]  bank_reg_b;
  logic        req_a, req_b, we_a, we_b;
  logic [23:0] addr_a, addr_b;
  logic        ack_a, ack_b;
  logic [7:0]  rd_val;

  int checks = 0, failures = 0;
  int lat_cfg = 0;
  bit resp_en = 1'b1;

  int m_cnt[2]      = '{4, 1};
  int m_mask[2]     = '{'h7F, 'h3FF};
  int m_raddr[2][4] = '{'{'h5000, 'h6000, 'h8000, 'hA000}, '{'h5000, 0, 0, 0}};
  int m_bank[2][4];

  always #5 CLK = ~CLK;

  megarom_mapper_engine u_dut_a (
    .CLK(CLK), .RESET_n(RESET_n), .BUS_RESET_n(BUS_RESET_n),
    .BUS_ADDR(bus_addr), .BUS_DIN(bus_din), .BUS_RD_n(rd_n), .BUS_WR_n(wr_n),
    .BUS_MERQ_n(merq_n), .BUS_SLTSL_n(sltsl_n),
    .BUS_DOUT(dout_a), .BUS_BUSDIR_n(busdir_a), .BUS_WAIT_n(wait_a),
    .CFG_TOP_ADDR(top), .CFG_BANK16(bank16), .CFG_WP(wp),
    .CFG_REG_ADDR_MASK(reg_addr_mask), .CFG_REG_ADDR(reg_addr_a),
    .CFG_REG_MASK(reg_mask_a), .CFG_REG_INIT(init_a), .BANK_REG(bank_reg_a),
    .RAM_REQ(req_a), .RAM_WE(we_a), .RAM_ADDR(addr_a), .RAM_WDATA(wdata_a),
    .RAM_ACK(ack_a), .RAM_RDATA(rd_val)
  );

  megarom_mapper_engine #(.BANK_COUNT(1), .BANK_BITS(10), .ADDR_WIDTH(24)) u_dut_b (
    .CLK(CLK), .RESET_n(RESET_n), .BUS_RESET_n(BUS_RESET_n),
    .BUS_ADDR(bus_addr), .BUS_DIN(bus_din), .BUS_RD_n(rd_n), .BUS_WR_n(wr_n),
    .BUS_MERQ_n(merq_n), .BUS_SLTSL_n(sltsl_n),
    .BUS_DOUT(dout_b), .BUS_BUSDIR_n(busdir_b), .BUS_WAIT_n(wait_b),
    .CFG_TOP_ADDR(top), .CFG_BANK16(bank16), .CFG_WP(wp),
    .CFG_REG_ADDR_MASK(reg_addr_mask), .CFG_REG_ADDR(reg_addr_b),
    .CFG_REG_MASK(reg_mask_b), .CFG_REG_INIT(init_b), .BANK_REG(bank_reg_b),
    .RAM_REQ(req_b), .RAM_WE(we_b), .RAM_ADDR(addr_b), .RAM_WDATA(wdata_b),
    .RAM_ACK(ack_b), .RAM_RDATA(rd_val)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Lowest register index whose address matches under the decode mask, -1 when none
  function automatic int reg_hit(int inst, int a);
    for (int i = 0; i < m_cnt[inst]; i++)
      if ((a & 'hF800) == m_raddr[inst][i]) return i;
    return -1;
  endfunction

  function automatic logic [23:0] model_addr(int inst, int a);
    int win, w, b;
    win = bank16 ? 'h4000 : 'h2000;
    w   = (a - 'h4000) / win;
    b   = (w < m_cnt[inst]) ? m_bank[inst][w] : w;
    return 24'((int'(top) + b * win + a % win) & 'hFFFFFF);
  endfunction

  function automatic logic [31:0] model_bank_a();
    logic [31:0] v = '0;
    for (int i = 0; i < 4; i++) v = v | (32'(m_bank[0][i]) << (8 * i));
    return v;
  endfunction

  task automatic model_bus_reset();
    for (int i = 0; i < 4; i++) m_bank[0][i] = (int'(init_a) >> (8 * i)) & 'hFF;
    m_bank[1][0] = int'(init_b);
  endtask

  task automatic model_write(input int a, input logic [7:0] d);
    for (int n = 0; n < 2; n++)
      for (int i = 0; i < m_cnt[n]; i++)
        if ((a & 'hF800) == m_raddr[n][i]) m_bank[n][i] = int'(d) & m_mask[n];
  endtask

  // RAM model: acks after lat_cfg idle cycles of an outstanding request
  initial begin
    int cnt = 0;
    ack_a = 1'b0;
    ack_b = 1'b0;
    rd_val = '0;
    forever begin
      @(negedge CLK);
      if (resp_en) begin
        ack_a = 1'b0;
        ack_b = 1'b0;
        if (req_a) begin
          if (cnt >= lat_cfg) begin
            ack_a = 1'b1;
            ack_b = req_b;
            cnt = 0;
          end else cnt++;
        end else cnt = 0;
      end
    end
  end

  task automatic access(input bit is_wr, input int a, input logic [7:0] d, input int lat, input logic [7:0] rv);
    bit win, exp_req, exp_rb;
    int hit_a, hit_b, cyc;
    logic [23:0] ea, eb;
    win    = (a >= 'h4000) && (a <= 'hBFFF);
    hit_a  = reg_hit(0, a);
    hit_b  = reg_hit(1, a);
    exp_rb = 1'b0;
`ifdef MEGAROM_READBACK_EN
    exp_rb = !is_wr && win && (hit_a >= 0);
`endif
    exp_req = win && !exp_rb && (!is_wr || !wp);
    ea = model_addr(0, a);
    eb = model_addr(1, a);
    lat_cfg = lat;
    rd_val  = rv;
    bus_addr = 16'(a);
    bus_din  = d;
    sltsl_n  = 1'b0;
    merq_n   = 1'b0;
    if (is_wr) wr_n = 1'b0; else rd_n = 1'b0;
    @(posedge CLK); #1;
    check("req_a", req_a, exp_req);
    check("req_b", req_b, exp_req);
    check("wait_n", wait_a, !exp_req);
    check("busdir_n", busdir_a, !(!is_wr && (exp_req || exp_rb)));
    if (exp_req) begin
      check("ram_addr_a", addr_a, ea);
      check("ram_addr_b", addr_b, eb);
      check("ram_we", we_a, is_wr);
      if (is_wr) check("ram_wdata", wdata_a, d);
    end
    if (exp_rb) begin
      check("rb_dout_a", dout_a, m_bank[0][hit_a] & 'hFF);
      check("rb_dout_b", dout_b, (hit_b >= 0) ? (m_bank[1][hit_b] & 'hFF) : 0);
      check("rb_wait_n", wait_a, 1);
    end else begin
      check("dout_idle", dout_a, 0);
    end
    if (is_wr) model_write(a, d);
    check("bank_a", bank_reg_a, model_bank_a());
    check("bank_b", bank_reg_b, m_bank[1][0]);
    if (exp_req) begin
      cyc = 0;
      while (req_a && cyc < 64) begin
        @(posedge CLK); #1;
        cyc++;
      end
      check("latency", cyc, lat + 1);
      check("wait_n_done", wait_a, 1);
      check("req_b_done", req_b, 0);
      check("dout_a", dout_a, is_wr ? 8'h00 : rv);
      check("dout_b", dout_b, is_wr ? 8'h00 : rv);
    end
    rd_n = 1'b1;
    wr_n = 1'b1;
    sltsl_n = 1'b1;
    merq_n = 1'b1;
    @(posedge CLK); #1;
    check("rel_busdir_n", busdir_a, 1);
    check("rel_dout", dout_a, 0);
    check("rel_req", req_a, 0);
  endtask

  initial begin
    int cyc, a, r;
    bit w;
    RESET_n = 1'b0;
    BUS_RESET_n = 1'b1;
    bus_addr = '0;
    bus_din = '0;
    rd_n = 1'b1;
    wr_n = 1'b1;
    merq_n = 1'b1;
    sltsl_n = 1'b1;
    top = 24'h100000;
    bank16 = 1'b0;
    wp = 1'b0;
    reg_addr_mask = 16'hF800;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_bank_a", bank_reg_a, 0);
    check("rst_bank_b", bank_reg_b, 0);
    check("rst_req", req_a, 0);
    check("rst_addr", addr_a, 0);
    check("rst_wait_n", wait_a, 1);
    check("rst_busdir_n", busdir_a, 1);
    check("rst_dout", dout_a, 0);

    RESET_n = 1'b1;
    BUS_RESET_n = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    model_bus_reset();
    check("init_bank_a", bank_reg_a, init_a);
    check("init_bank_b", bank_reg_b, init_b);
    BUS_RESET_n = 1'b1;
    @(posedge CLK); #1;

    // 8 KB mapping through a freshly written register
    access(1, 'h8000, 8'h05, 1, 8'h00);
    access(0, 'h8123, 8'h00, 2, 8'hA5);
    check("tp_addr_a", addr_a, 24'h10A123);
    check("tp_addr_b", addr_b, 24'h104123);

    // 16 KB mode: single-register mapper falls back to identity bank 1
    bank16 = 1'b1;
    access(0, 'h8001, 8'h00, 0, 8'h3E);
    check("tp16_addr_b", addr_b, 24'h104001);

    // Write protect: register decode only
    bank16 = 1'b0;
    wp = 1'b1;
    access(1, 'h6000, 8'h55, 0, 8'h00);
    check("wp_bank1", bank_reg_a[15:8], 8'h55);

    // Bus reset mid-transaction, then a stale ack
    wp = 1'b0;
    resp_en = 1'b0;
    bus_addr = 16'h4100;
    sltsl_n = 1'b0;
    merq_n = 1'b0;
    rd_n = 1'b0;
    @(posedge CLK); #1;
    check("br_req_pre", req_a, 1);
    BUS_RESET_n = 1'b0;
    @(posedge CLK); #1;
    model_bus_reset();
    check("br_req", req_a, 0);
    check("br_wait_n", wait_a, 1);
    check("br_busdir_n", busdir_a, 1);
    check("br_bank_a", bank_reg_a, init_a);
    check("br_bank_b", bank_reg_b, init_b);
    BUS_RESET_n = 1'b1;
    ack_a = 1'b1;
    ack_b = 1'b1;
    rd_val = 8'hEE;
    @(posedge CLK); #1;
    ack_a = 1'b0;
    ack_b = 1'b0;
    check("late_ack_req", req_a, 0);
    check("late_ack_dout", dout_a, 0);
    check("late_ack_busdir_n", busdir_a, 1);
    rd_n = 1'b1;
    sltsl_n = 1'b1;
    merq_n = 1'b1;
    @(posedge CLK); #1;
    resp_en = 1'b1;

    // Address wrap past the top of RAM
    top = 24'hFFE000;
    wp = 1'b1;
    access(1, 'h5000, 8'h01, 0, 8'h00);
    wp = 1'b0;
    access(0, 'h4010, 8'h00, 1, 8'h77);
    check("wrap_addr_a", addr_a, 24'h000010);

    // Strobe released while the RAM is still busy
    lat_cfg = 4;
    rd_val = 8'h99;
    bus_addr = 16'h9000;
    sltsl_n = 1'b0;
    merq_n = 1'b0;
    rd_n = 1'b0;
    @(posedge CLK); #1;
    check("early_req", req_a, 1);
    rd_n = 1'b1;
    sltsl_n = 1'b1;
    merq_n = 1'b1;
    @(posedge CLK); #1;
    check("early_busdir_n", busdir_a, 1);
    cyc = 0;
    while (req_a && cyc < 64) begin
      @(posedge CLK); #1;
      cyc++;
    end
    check("early_done_req", req_a, 0);
    check("early_wait_n", wait_a, 1);
    check("early_dout", dout_a, 0);
    check("early_busdir_done", busdir_a, 1);
    @(posedge CLK); #1;

    // Register read of reg 0 after writing it
    wp = 1'b1;
    access(1, 'h5000, 8'h3C, 0, 8'h00);
    wp = 1'b0;
    access(0, 'h5000, 8'h00, 1, 8'h42);

    for (int n = 0; n < 200; n++) begin
      r = int'($urandom_range(0, 9));
      bank16 = 1'($urandom_range(0, 1));
      wp = ($urandom_range(0, 3) == 0);
      top = 24'($urandom);
      w = 1'($urandom_range(0, 1));
      if (r < 6) a = int'($urandom_range('h4000, 'hBFFF));
      else if (r < 8) a = m_raddr[0][$urandom_range(0, 3)] | int'($urandom_range(0, 'h7FF));
      else a = int'($urandom_range(0, 'hFFFF));
`ifdef MEGAROM_READBACK_EN
      if (!w && ((reg_hit(0, a) >= 0) != (reg_hit(1, a) >= 0))) w = 1'b1;
`endif
      access(w, a, 8'($urandom), int'($urandom_range(0, 4)), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
